// File: rtl/uart_rx_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_rx_pkg
// Description : Shared types and sizing helpers for the parametrised UART
//               receive deserialiser.
//               - rx_state_t : receive state encoding
//               - tick_cnt_w : width of the oversampling tick counter
//               - bit_cnt_w  : width of the data/stop bit counter
// Revision    : 1.0 - initial release
// ============================================================================
package uart_rx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } rx_state_t;

   // Tick counter must reach OVERSAMPLE-1.
   function automatic int tick_cnt_w(input int oversample);
      return (oversample > 1) ? $clog2(oversample) : 1;
   endfunction

   // Bit counter must reach max(DATA_BITS, STOP_BITS)-1.
   function automatic int bit_cnt_w(input int data_bits, input int stop_bits);
      int m;
      m = (data_bits > stop_bits) ? data_bits : stop_bits;
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_rx_sync
// Description : Two-flop synchroniser for the asynchronous serial line plus a
//               falling-edge detector on the synchronised signal.
// Ports       : clk      in  - oversampling clock
//               reset_n  in  - synchronous active-low reset
//               data_tx  in  - raw serial line (idle high)
//               rx_s     out - synchronised line
//               fall_s   out - one-cycle pulse when rx_s goes 1 -> 0
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sync
   import uart_rx_pkg::*;
(
   input  logic clk,
   input  logic reset_n,
   input  logic data_tx,
   output logic rx_s,
   output logic fall_s
);

   logic r_meta;
   logic r_sync;
   logic r_sync_d;

   // All stages reset to 1 so that leaving reset on an idle line never
   // looks like a start edge.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_meta   <= 1'b1;
         r_sync   <= 1'b1;
         r_sync_d <= 1'b1;
      end else begin
         r_meta   <= data_tx;
         r_sync   <= r_meta;
         r_sync_d <= r_sync;
      end
   end

   assign rx_s   = r_sync;
   assign fall_s = r_sync_d & ~r_sync;

endmodule
`default_nettype wire

// File: rtl/uart_rx_sipo_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_rx_sipo_param
// Description : Parametrised UART receive deserialiser. Oversamples the line
//               on baud_clk, rejects false starts, shifts in DATA_BITS LSB
//               first, checks optional parity and STOP_BITS stop bits, and
//               holds the word on a valid/acknowledge handshake.
//               Optional feature macro: UART_RX_PARITY_EN (parity bit after
//               the data; parity_err tied to 0 when undefined).
// Ports       : baud_clk      in  - oversampling clock
//               reset_n       in  - synchronous active-low reset
//               data_tx       in  - serial line, idle high, asynchronous
//               rd_ack        in  - consumer accepts the held word
//               active_flag   out - frame reception in progress
//               recieved_flag out - data_parll and error flags valid
//               data_parll    out - received word
//               frame_err     out - a stop-bit sample was 0
//               parity_err    out - parity mismatch
//               overrun_err   out - unacknowledged word was overwritten
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sipo_param
   import uart_rx_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter int STOP_BITS  = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic                 baud_clk,
   input  logic                 reset_n,
   input  logic                 data_tx,
   input  logic                 rd_ack,
   output logic                 active_flag,
   output logic                 recieved_flag,
   output logic [DATA_BITS-1:0] data_parll,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 overrun_err
);

   localparam int C_TICK_W = tick_cnt_w(OVERSAMPLE);
   localparam int C_BIT_W  = bit_cnt_w(DATA_BITS, STOP_BITS);

   localparam logic [C_TICK_W-1:0] C_TICK_LAST = C_TICK_W'(OVERSAMPLE - 1);
   localparam logic [C_TICK_W-1:0] C_TICK_HALF = C_TICK_W'(OVERSAMPLE/2 - 1);
   localparam logic [C_BIT_W-1:0]  C_DATA_LAST = C_BIT_W'(DATA_BITS - 1);
   localparam logic [C_BIT_W-1:0]  C_STOP_LAST = C_BIT_W'(STOP_BITS - 1);

   logic w_rx_s;
   logic w_fall_s;

   rx_state_t              r_state;
   logic [C_TICK_W-1:0]    r_tick_cnt;
   logic [C_BIT_W-1:0]     r_bit_cnt;
   logic [DATA_BITS-1:0]   r_shift;
   logic                   r_stop_err;   // earlier stop bit (of two) was 0
   logic                   r_active;
   logic                   r_received;
   logic [DATA_BITS-1:0]   r_data;
   logic                   r_frame_err;
   logic                   r_overrun;
`ifdef UART_RX_PARITY_EN
   logic                   r_par_bit;
   logic                   r_parity_err;
`endif

   uart_rx_sync u_sync (
      .clk     (baud_clk),
      .reset_n (reset_n),
      .data_tx (data_tx),
      .rx_s    (w_rx_s),
      .fall_s  (w_fall_s)
   );

   always_ff @(posedge baud_clk) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_tick_cnt  <= '0;
         r_bit_cnt   <= '0;
         r_shift     <= '0;
         r_stop_err  <= 1'b0;
         r_active    <= 1'b0;
         r_received  <= 1'b0;
         r_data      <= '0;
         r_frame_err <= 1'b0;
         r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_par_bit    <= 1'b0;
         r_parity_err <= 1'b0;
`endif
      end else begin
         // Consumer handshake; a completion in the same cycle overrides
         // these assignments further down.
         if (r_received && rd_ack) begin
            r_received  <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parity_err <= 1'b0;
`endif
         end

         case (r_state)
            ST_IDLE: begin
               if (w_fall_s) begin
                  r_state    <= ST_START;
                  r_tick_cnt <= '0;
                  r_active   <= 1'b1;
               end
            end

            // Re-check the line half a bit in; a high level is a glitch.
            ST_START: begin
               if (r_tick_cnt == C_TICK_HALF) begin
                  r_tick_cnt <= '0;
                  r_bit_cnt  <= '0;
                  if (w_rx_s) begin
                     r_state  <= ST_IDLE;
                     r_active <= 1'b0;
                  end else begin
                     r_state <= ST_DATA;
                  end
               end else begin
                  r_tick_cnt <= r_tick_cnt + 1'b1;
               end
            end

            ST_DATA: begin
               if (r_tick_cnt == C_TICK_LAST) begin
                  r_tick_cnt <= '0;
                  r_shift    <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                  if (r_bit_cnt == C_DATA_LAST) begin
                     r_bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                     r_state <= ST_PARITY;
`else
                     r_state <= ST_STOP;
`endif
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 1'b1;
                  end
               end else begin
                  r_tick_cnt <= r_tick_cnt + 1'b1;
               end
            end

`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
               if (r_tick_cnt == C_TICK_LAST) begin
                  r_tick_cnt <= '0;
                  r_par_bit  <= w_rx_s;
                  r_state    <= ST_STOP;
               end else begin
                  r_tick_cnt <= r_tick_cnt + 1'b1;
               end
            end
`endif

            ST_STOP: begin
               if (r_tick_cnt == C_TICK_LAST) begin
                  r_tick_cnt <= '0;
                  if (r_bit_cnt == C_STOP_LAST) begin
                     // Last stop sample: deliver the word, errored or not.
                     r_state     <= ST_IDLE;
                     r_active    <= 1'b0;
                     r_bit_cnt   <= '0;
                     r_stop_err  <= 1'b0;
                     r_data      <= r_shift;
                     r_frame_err <= r_stop_err | ~w_rx_s;
                     r_received  <= 1'b1;
                     r_overrun   <= r_received & ~rd_ack;
`ifdef UART_RX_PARITY_EN
                     r_parity_err <= (^r_shift) ^ r_par_bit ^ 1'(PARITY_ODD);
`endif
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 1'b1;
                     if (!w_rx_s) begin
                        r_stop_err <= 1'b1;
                     end
                  end
               end else begin
                  r_tick_cnt <= r_tick_cnt + 1'b1;
               end
            end

            default: begin
               r_state  <= ST_IDLE;
               r_active <= 1'b0;
            end
         endcase
      end
   end

   assign active_flag   = r_active;
   assign recieved_flag = r_received;
   assign data_parll    = r_data;
   assign frame_err     = r_frame_err;
   assign overrun_err   = r_overrun;
`ifdef UART_RX_PARITY_EN
   assign parity_err    = r_parity_err;
`else
   // No parity bit on the line; PARITY_ODD has no effect in this build.
   assign parity_err    = 1'b0 & 1'(PARITY_ODD);
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_sipo_param.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_sipo_param
// Description : Self-checking bench for uart_rx_sipo_param (default params).
//               A line driver serialises frames and queues the expected word;
//               a monitor pops and compares each word the DUT presents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_sipo_param;

   localparam int DB  = 8;
   localparam int OS  = 16;
   localparam int SB  = 1;
   localparam int ODD = 0;
`ifdef UART_RX_PARITY_EN
   localparam int PB  = 1;
`else
   localparam int PB  = 0;
`endif
   localparam int NBITS = DB + PB + SB;
   // Cycles from the line falling to recieved_flag rising:
   // 2 synchroniser cycles, then half a bit, NBITS bit periods, plus one.
   localparam int LAT   = 2 + OS/2 + NBITS*OS + 1;

   logic          baud_clk = 1'b0;
   logic          reset_n  = 1'b0;
   logic          data_tx  = 1'b1;
   logic          rd_ack   = 1'b0;
   logic          active_flag;
   logic          recieved_flag;
   logic [DB-1:0] data_parll;
   logic          frame_err;
   logic          parity_err;
   logic          overrun_err;

   uart_rx_sipo_param #(
      .DATA_BITS  (DB),
      .OVERSAMPLE (OS),
      .STOP_BITS  (SB),
      .PARITY_ODD (ODD)
   ) dut (
      .baud_clk      (baud_clk),
      .reset_n       (reset_n),
      .data_tx       (data_tx),
      .rd_ack        (rd_ack),
      .active_flag   (active_flag),
      .recieved_flag (recieved_flag),
      .data_parll    (data_parll),
      .frame_err     (frame_err),
      .parity_err    (parity_err),
      .overrun_err   (overrun_err)
   );

   always #5 baud_clk = ~baud_clk;

   int cyc = 0;
   always @(posedge baud_clk) cyc <= cyc + 1;

   typedef struct {
      logic [DB-1:0] data;
      logic          ferr;
      logic          perr;
      logic          ovr;
      int            due;
   } exp_t;

   exp_t sb_q[$];
   int   checks  = 0;
   int   errors  = 0;
   bit   auto_ack = 1'b1;
   bit   pending  = 1'b0;   // a delivered word is still unacknowledged
   bit   mon_ack  = 1'b0;
   logic prev_rf  = 1'b0;
   logic prev_ov  = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge baud_clk);
      #1;
   endtask

   task automatic wait_cyc(input int c);
      while (cyc < c) tick(1);
   endtask

   task automatic drive_bit(input logic b);
      data_tx = b;
      tick(OS);
   endtask

   // Serialise one frame and queue the word the receiver must deliver.
   task automatic send_frame(input logic [DB-1:0] d, input bit bad_par,
                             input bit bad_stop, input int gap);
      exp_t e;
      logic p;
      e.data = d;
      e.ferr = bad_stop;
      e.perr = (PB == 1) ? bad_par : 1'b0;
      e.ovr  = pending;
      e.due  = cyc + LAT;
      sb_q.push_back(e);
      pending = !auto_ack;
      drive_bit(1'b0);
      for (int i = 0; i < DB; i++) drive_bit(d[i]);
      if (PB == 1) begin
         p = (^d) ^ 1'(ODD) ^ bad_par;
         drive_bit(p);
      end
      for (int s = 0; s < SB; s++) drive_bit(!bad_stop);
      data_tx = 1'b1;
      tick(gap);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_rf"},     recieved_flag, 0);
      check({tag, "_data"},   data_parll,    0);
      check({tag, "_active"}, active_flag,   0);
      check({tag, "_ferr"},   frame_err,     0);
      check({tag, "_perr"},   parity_err,    0);
      check({tag, "_ovr"},    overrun_err,   0);
   endtask

   task automatic wait_drain(input int limit);
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < limit) begin
         tick(1);
         n++;
      end
      if (sb_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout actual=%0d words outstanding required=0", sb_q.size());
         sb_q.delete();
      end
   endtask

   // Monitor: a new word is presented when recieved_flag rises, or when an
   // overrun replaces the held word (overrun_err rises while flag stays 1).
   initial begin
      exp_t e;
      forever begin
         @(posedge baud_clk);
         #1;
         if (mon_ack) begin
            rd_ack  = 1'b0;
            mon_ack = 1'b0;
         end
         if (recieved_flag && (!prev_rf || (overrun_err && !prev_ov))) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_word actual=%0h required=none (cycle %0d)", data_parll, cyc);
            end else begin
               e = sb_q.pop_front();
               check("rx_data",  data_parll,  e.data);
               check("rx_ferr",  frame_err,   e.ferr);
               check("rx_perr",  parity_err,  e.perr);
               check("rx_ovr",   overrun_err, e.ovr);
               check("rx_cycle", cyc,         e.due);
               if (auto_ack) begin
                  rd_ack  = 1'b1;
                  mon_ack = 1'b1;
               end
            end
         end
         prev_rf = recieved_flag;
         prev_ov = overrun_err;
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      int k;
      reset_n = 1'b0;
      tick(3);
      check_all_zero("reset");
      reset_n = 1'b1;
      tick(4);

      // Clean frame with active_flag window checks.
      k = cyc;
      fork
         send_frame(8'hA5, 1'b0, 1'b0, 20);
         begin
            wait_cyc(k + 2 + OS/2);
            check("active_mid", active_flag, 1);
            wait_cyc(k + LAT - 1);
            check("active_last", active_flag, 1);
            tick(1);
            check("active_end", active_flag, 0);
         end
      join

      // Bad parity, then bad stop followed by a clean frame.
      send_frame(8'hA5, 1'b1, 1'b0, 20);
      send_frame(8'h3C, 1'b0, 1'b1, 20);
      send_frame(8'h96, 1'b0, 1'b0, 20);

      // False start: 4-cycle low glitch.
      k = cyc;
      data_tx = 1'b0;
      tick(4);
      data_tx = 1'b1;
      wait_cyc(k + 2 + OS/2);
      check("false_active_hold", active_flag, 1);
      tick(1);
      check("false_active_drop", active_flag, 0);
      tick(2*OS*NBITS);
      wait_drain(4*LAT);

      // Overrun: two words without acknowledge.
      auto_ack = 1'b0;
      pending  = 1'b0;
      send_frame(8'h11, 1'b0, 1'b0, 20);
      send_frame(8'h22, 1'b0, 1'b0, 20);
      wait_drain(4*LAT);
      check("ovr_rf_held", recieved_flag, 1);
      check("ovr_flag",    overrun_err,   1);
      rd_ack = 1'b1;
      tick(1);
      rd_ack = 1'b0;
      pending = 1'b0;
      check("ack_rf_clear",  recieved_flag, 0);
      check("ack_ovr_clear", overrun_err,   0);
      check("ack_data_keep", data_parll,    8'h22);
      tick(5);

      // Reset mid-frame with a word pending, then a clean frame.
      send_frame(8'h5A, 1'b0, 1'b0, 10);
      wait_drain(4*LAT);
      data_tx = 1'b0;
      tick(OS);
      for (int i = 0; i < 4; i++) drive_bit(1'b0);
      data_tx = 1'b1;               // bit 4 of 0xF0
      tick(OS/2);
      reset_n = 1'b0;
      tick(1);
      check_all_zero("midreset");
      reset_n = 1'b1;
      pending = 1'b0;
      tick(12*OS);
      auto_ack = 1'b1;
      send_frame(8'h7E, 1'b0, 1'b0, 20);

      // Randomised frames.
      for (int i = 0; i < 12; i++) begin
         send_frame(DB'($urandom), ($urandom_range(0, 3) == 0),
                    ($urandom_range(0, 3) == 0), $urandom_range(1, 40));
      end

      wait_drain(4*LAT);
      tick(2*LAT);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
